// File: rtl/vec_pkg.sv
// Shared types for the vector writeback path: op-type codes, default VLEN,
// collector state encoding and the SEW decode helper.
package vec_pkg;

  typedef enum logic [1:0] {
    OP_VV = 2'd0,
    OP_VX = 2'd1,
    OP_VI = 2'd2
  } vec_op_e;

  localparam int VLEN_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } wb_state_e;

  function automatic int unsigned sew_bits(input logic [2:0] vsew);
    return 32'd8 << vsew;
  endfunction

endpackage

// File: rtl/vec_wb_collector_if.sv
// Register-file write port of the collector: valid/ready request with address and data.
interface vec_wb_collector_if #(
  parameter int VLEN = 128
);
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_addr;
  logic [VLEN-1:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_addr, input wb_data, output wb_ready);
endinterface

// File: rtl/vec_wb_lane_insert.sv
// Inserts one lane chunk of width i_w at bit i_idx into the accumulator image;
// a chunk that would run past the top of the register is dropped whole.
module vec_wb_lane_insert #(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0] i_acc,
  input  logic [63:0]     i_chunk,
  input  logic [9:0]      i_idx,
  input  logic [6:0]      i_w,
  input  logic            i_en,
  output logic [VLEN-1:0] o_acc
);

  logic w_fits;
  assign w_fits = (32'(i_idx) + 32'(i_w)) <= 32'(VLEN);

  always_comb begin
    o_acc = i_acc;
    if (i_en && w_fits) begin
      for (int b = 0; b < VLEN; b++) begin
        if (b >= int'(i_idx) && b < int'(i_idx) + int'(i_w))
          o_acc[b] = i_chunk[6'(b - int'(i_idx))];
      end
    end
  end

endmodule

// File: rtl/vec_wb_collector.sv
// Assembles per-lane ALU chunks into one vector register image and writes it back.
// Optional feature macro: VEC_WB_MASK_EN (mask-undisturbed merge with old_vd).
//
// state   | meaning
// IDLE    | waiting for a rising run; wb outputs quiet
// COLLECT | capturing aligned lane chunks into the accumulator
// WRITE   | wb_valid held with stable addr/data until wb_ready
// DONE    | one-cycle wb_done pulse
module vec_wb_collector
  import vec_pkg::*;
#(
  parameter int VLEN       = VLEN_DEF,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 2,
  parameter int ALU_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       run,
  input  logic [2:0]                 vsew,
  input  logic [4:0]                 vd_sel,
  input  logic [(64<<NB_LANES)-1:0]  lane_vd,
  input  logic [(10<<NB_LANES)-1:0]  lane_idx,
  input  logic [(1<<NB_LANES)-1:0]   lane_en,
  input  logic                       alu_done,
  input  logic [VLEN-1:0]            old_vd,
  input  logic [VLEN/8-1:0]          vmask,
  vec_wb_collector_if.master         wb,
  output logic                       wb_done,
  output logic                       busy
);

  localparam int LANES = 1 << NB_LANES;
  localparam int unsigned CW_MAX = 32'd1 << LANE_WIDTH;

  wb_state_e r_state, w_state_n;
  logic            r_run_d;
  logic [4:0]      r_vd;
  logic [VLEN-1:0] r_acc;
  logic            w_start;
  logic [6:0]      w_cw;

  logic [10*LANES-1:0] r_idx_pipe  [ALU_LAT];
  logic [LANES-1:0]    r_en_pipe   [ALU_LAT];
  logic                r_done_pipe [ALU_LAT];
  logic [10*LANES-1:0] w_al_idx;
  logic [LANES-1:0]    w_al_en;
  logic                w_al_done;

  // Issue-time controls are delayed to meet their results; a low run flushes them.
  always_ff @(posedge clk) begin
    if (!resetn || !run) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        r_idx_pipe[i]  <= '0;
        r_en_pipe[i]   <= '0;
        r_done_pipe[i] <= 1'b0;
      end
    end else begin
      r_idx_pipe[0]  <= lane_idx;
      r_en_pipe[0]   <= lane_en;
      r_done_pipe[0] <= alu_done;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_idx_pipe[i]  <= r_idx_pipe[i-1];
        r_en_pipe[i]   <= r_en_pipe[i-1];
        r_done_pipe[i] <= r_done_pipe[i-1];
      end
    end
  end

  assign w_al_idx  = r_idx_pipe[ALU_LAT-1];
  assign w_al_en   = r_en_pipe[ALU_LAT-1];
  assign w_al_done = r_done_pipe[ALU_LAT-1];

  assign w_cw = 7'((sew_bits(vsew) < CW_MAX) ? sew_bits(vsew) : CW_MAX);

  logic [VLEN-1:0] w_acc_chain [LANES+1];
  assign w_acc_chain[0] = r_acc;

  // Chained in lane order so the highest lane owns overlapping bits.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vec_wb_lane_insert #(.VLEN(VLEN)) u_ins (
      .i_acc   (w_acc_chain[k]),
      .i_chunk (lane_vd[k*64 +: 64]),
      .i_idx   (w_al_idx[k*10 +: 10]),
      .i_w     (w_cw),
      .i_en    (w_al_en[k]),
      .o_acc   (w_acc_chain[k+1])
    );
  end

  // Only a fresh rise of run arms a write, so a run held across DONE cannot repeat it.
  assign w_start = (r_state == ST_IDLE) && run && !r_run_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_run_d <= 1'b0;
      r_vd    <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_n;
      r_run_d <= run;
      if (w_start) begin
        r_vd  <= vd_sel;
        r_acc <= '0;
      end else if (r_state == ST_COLLECT && run) begin
        r_acc <= w_acc_chain[LANES];
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    wb.wb_valid = 1'b0;
    wb_done     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_start) w_state_n = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!run)           w_state_n = ST_IDLE;
        else if (w_al_done) w_state_n = ST_WRITE;
      end
      ST_WRITE: begin
        wb.wb_valid = 1'b1;
        if (!run)             w_state_n = ST_IDLE;
        else if (wb.wb_ready) w_state_n = ST_DONE;
      end
      ST_DONE: begin
        wb_done   = 1'b1;
        w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign wb.wb_addr = r_vd;

`ifdef VEC_WB_MASK_EN
  localparam int MW = $clog2(VLEN/8);
  logic [VLEN-1:0] w_merge;
  logic [VLEN-1:0] r_wb_data;

  always_comb begin
    int e;
    e       = 0;
    w_merge = old_vd;
    for (int b = 0; b < VLEN; b++) begin
      e = b >> (int'(vsew) + 3);
      if (vmask[MW'(e)]) w_merge[b] = w_acc_chain[LANES][b];
    end
  end

  // old_vd and vmask are sampled on the same edge that enters WRITE.
  always_ff @(posedge clk) begin
    if (!resetn)                                       r_wb_data <= '0;
    else if (r_state == ST_COLLECT && run && w_al_done) r_wb_data <= w_merge;
  end

  assign wb.wb_data = r_wb_data;
`else
  logic w_unused;
  assign w_unused   = ^{old_vd, vmask};
  assign wb.wb_data = r_acc;
`endif

endmodule

// File: tb/tb_vec_wb_collector.sv
// Directed plus randomized bench for vec_wb_collector with a chunk-level reference model.
module tb_vec_wb_collector;
  import vec_pkg::*;

  logic         clk;
  logic         resetn;
  logic         run;
  logic [2:0]   vsew;
  logic [4:0]   vd_sel;
  logic [255:0] lane_vd;
  logic [39:0]  lane_idx;
  logic [3:0]   lane_en;
  logic         alu_done;
  logic [127:0] old_vd;
  logic [15:0]  vmask;
  logic         wb_done;
  logic         busy;

  vec_wb_collector_if #(.VLEN(128)) wb_if ();

  vec_wb_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(2), .ALU_LAT(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .vsew     (vsew),
    .vd_sel   (vd_sel),
    .lane_vd  (lane_vd),
    .lane_idx (lane_idx),
    .lane_en  (lane_en),
    .alu_done (alu_done),
    .old_vd   (old_vd),
    .vmask    (vmask),
    .wb       (wb_if),
    .wb_done  (wb_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [9:0]  t_idx [16][4];
  bit          t_en  [16][4];
  logic [63:0] t_dat [16][4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input int n, input int sew);
    logic [127:0] a;
    logic [127:0] m;
    int w;
    a = '0;
    w = ((8 << sew) < 8) ? (8 << sew) : 8;
    for (int c = 0; c < n; c++)
      for (int k = 0; k < 4; k++)
        if (t_en[c][k] && (int'(t_idx[c][k]) + w <= 128)) begin
          m = ((128'd1 << w) - 128'd1) << t_idx[c][k];
          a = (a & ~m) | ((128'(t_dat[c][k]) << t_idx[c][k]) & m);
        end
    return a;
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] acc, input logic [127:0] old,
                                         input logic [15:0] m, input int sew);
    logic [127:0] r;
    logic [127:0] em;
    int sb;
    sb = 8 << sew;
    r  = old;
    em = (sb >= 128) ? '1 : ((128'd1 << sb) - 128'd1);
    for (int e = 0; e < 128 / sb; e++)
      if (m[e]) r = (r & ~(em << (e * sb))) | (acc & (em << (e * sb)));
    return r;
  endfunction

  task automatic clear_tbl();
    for (int c = 0; c < 16; c++)
      for (int k = 0; k < 4; k++) begin
        t_idx[c][k] = 10'($urandom);
        t_en[c][k]  = 1'b0;
        t_dat[c][k] = {$urandom, $urandom};
      end
  endtask

  task automatic run_op(input string tag, input int n, input logic [2:0] sew, input logic [4:0] vd,
                        input int rdy_delay, input bit rdy_early);
    logic [127:0] exp_d;
    exp_d = model(n, int'(sew));
`ifdef VEC_WB_MASK_EN
    exp_d = merge(exp_d, old_vd, vmask, int'(sew));
`endif
    for (int c = 0; c <= n; c++) begin
      run      = 1'b1;
      vsew     = sew;
      vd_sel   = (c == 0) ? vd : 5'($urandom);
      lane_en  = '0;
      lane_idx = 40'({$urandom, $urandom});
      for (int k = 0; k < 4; k++) begin
        if (c < n) begin
          lane_idx[k*10 +: 10] = t_idx[c][k];
          lane_en[k]           = t_en[c][k];
        end
        lane_vd[k*64 +: 64] = (c > 0) ? t_dat[c-1][k] : {$urandom, $urandom};
      end
      alu_done       = (c == n - 1);
      wb_if.wb_ready = rdy_early;
      step();
      check({tag, ":busy"}, 128'(busy), 128'(1));
      if (c < n) check({tag, ":valid_early"}, 128'(wb_if.wb_valid), 128'(0));
    end
    lane_en  = '0;
    alu_done = 1'b0;
    for (int d = 0; d < rdy_delay; d++) begin
      wb_if.wb_ready = 1'b0;
      vd_sel         = 5'($urandom);
      check({tag, ":valid_hold"}, 128'(wb_if.wb_valid), 128'(1));
      check({tag, ":data_hold"}, wb_if.wb_data, exp_d);
      step();
    end
    wb_if.wb_ready = 1'b1;
    check({tag, ":valid"}, 128'(wb_if.wb_valid), 128'(1));
    check({tag, ":addr"}, 128'(wb_if.wb_addr), 128'(vd));
    check({tag, ":data"}, wb_if.wb_data, exp_d);
    check({tag, ":no_done_yet"}, 128'(wb_done), 128'(0));
    step();
    wb_if.wb_ready = 1'b0;
    check({tag, ":done"}, 128'(wb_done), 128'(1));
    check({tag, ":valid_off"}, 128'(wb_if.wb_valid), 128'(0));
    step();
    check({tag, ":done_once"}, 128'(wb_done), 128'(0));
    check({tag, ":idle"}, 128'(busy), 128'(0));
    step();
    check({tag, ":no_rearm"}, 128'(busy), 128'(0));
    run = 1'b0;
    step();
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; vsew = '0; vd_sel = '0; lane_vd = '0; lane_idx = '0;
    lane_en = '0; alu_done = 1'b0; old_vd = '0; vmask = '0; wb_if.wb_ready = 1'b1;
    step();
    step();
    check("rst:valid", 128'(wb_if.wb_valid), 128'(0));
    check("rst:done", 128'(wb_done), 128'(0));
    check("rst:busy", 128'(busy), 128'(0));
    check("rst:addr", 128'(wb_if.wb_addr), 128'(0));
    check("rst:data", wb_if.wb_data, 128'(0));
    resetn = 1'b1;
    wb_if.wb_ready = 1'b0;
    step();

    // Bytes 0x11..0x44 across four lanes and four cycles, write stalled 5 cycles.
    old_vd = '1; vmask = '1;
    clear_tbl();
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        t_idx[c][k] = 10'((c * 4 + k) * 8);
        t_en[c][k]  = 1'b1;
        t_dat[c][k] = {56'({$urandom, $urandom}), 4'(c + 1), 4'(k + 1)};
      end
    run_op("bytes", 4, 3'd0, 5'd3, 5, 1'b0);

    // 64-bit elements built byte by byte on lane 0, ready held high from the start.
    begin
      logic [127:0] kpat;
      kpat = {64'hFEDCBA98_76543210, 64'h01234567_89ABCDEF};
      clear_tbl();
      for (int c = 0; c < 16; c++) begin
        t_idx[c][0] = 10'(c * 8);
        t_en[c][0]  = 1'b1;
        t_dat[c][0] = {56'({$urandom, $urandom}), kpat[c*8 +: 8]};
      end
      run_op("sew64", 16, 3'd3, 5'd17, 0, 1'b1);
    end

    // Overlap (lane 1 beats lane 0) and out-of-range drops.
    clear_tbl();
    t_idx[0][0] = 10'd0;   t_en[0][0] = 1'b1; t_dat[0][0] = 64'hAA;
    t_idx[0][1] = 10'd0;   t_en[0][1] = 1'b1; t_dat[0][1] = 64'h5C;
    t_idx[0][2] = 10'd124; t_en[0][2] = 1'b1; t_dat[0][2] = 64'hFF;
    t_idx[1][3] = 10'd1023; t_en[1][3] = 1'b1; t_dat[1][3] = '1;
    t_idx[1][0] = 10'd120; t_en[1][0] = 1'b1; t_dat[1][0] = 64'h77;
    run_op("edge", 2, 3'd0, 5'd30, 1, 1'b0);

    // Abort two cycles into COLLECT, then a sparse op must see a cleared accumulator.
    run = 1'b1; vd_sel = 5'd5; vsew = 3'd0; alu_done = 1'b0;
    lane_en = 4'hF; lane_idx = {10'd24, 10'd16, 10'd8, 10'd0};
    step();
    lane_vd = '1; lane_idx = {10'd56, 10'd48, 10'd40, 10'd32};
    step();
    check("abort:busy", 128'(busy), 128'(1));
    run = 1'b0; lane_en = '0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("abort:idle", 128'(busy), 128'(0));
      check("abort:valid", 128'(wb_if.wb_valid), 128'(0));
      check("abort:done", 128'(wb_done), 128'(0));
      step();
    end
    clear_tbl();
    t_idx[0][0] = 10'd64; t_en[0][0] = 1'b1; t_dat[0][0] = 64'h3C;
    run_op("after_abort", 1, 3'd0, 5'd6, 0, 1'b0);

    // Reset while WRITE is pending.
    run = 1'b1; vd_sel = 5'd9; vsew = 3'd0; lane_en = 4'h1; lane_idx = '0; alu_done = 1'b1;
    step();
    lane_en = '0; alu_done = 1'b0; lane_vd = {4{64'h99}};
    step();
    check("rstw:valid_pre", 128'(wb_if.wb_valid), 128'(1));
    resetn = 1'b0;
    step();
    check("rstw:valid", 128'(wb_if.wb_valid), 128'(0));
    check("rstw:busy", 128'(busy), 128'(0));
    check("rstw:addr", 128'(wb_if.wb_addr), 128'(0));
    check("rstw:data", wb_if.wb_data, 128'(0));
    resetn = 1'b1; run = 1'b0;
    step();

`ifdef VEC_WB_MASK_EN
    clear_tbl();
    old_vd = '1; vmask = 16'h0005;
    run_op("mask", 1, 3'd2, 5'd12, 0, 1'b0);
    check("mask:const", wb_if.wb_data === 128'hFFFFFFFF_00000000_FFFFFFFF_00000000 ? 128'(1) : 128'(0),
          128'(1));
`endif

    for (int op = 0; op < 15; op++) begin
      int n;
      clear_tbl();
      n = $urandom_range(1, 8);
      for (int c = 0; c < n; c++)
        for (int k = 0; k < 4; k++) begin
          t_idx[c][k] = 10'($urandom_range(0, 135));
          t_en[c][k]  = 1'($urandom);
        end
      old_vd = {$urandom, $urandom, $urandom, $urandom};
      vmask  = 16'($urandom);
      if (op % 4 == 3) run_op("rand", n, 3'($urandom_range(0, 3)), 5'($urandom), 0, 1'b1);
      else             run_op("rand", n, 3'($urandom_range(0, 3)), 5'($urandom), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
